afu_read_streamer: RTL and testbench

//  Upstream feeder for the 32x32 transpose AFU. Issues ctx_length cache-line read requests from
//  ctx_base_addr upward, and pushes each 512-bit read response, in order, into the transpose input FIFO.

---
 rtl/afu_read_streamer.sv | 136 +++++++++++++
 tb/tb_afu_read_streamer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/afu_read_streamer.sv
// Read-request streamer feeding the transpose AFU input FIFO: issues line reads,
// forwards in-order responses to the FIFO, throttles on almost-full and in-flight cap.
module afu_read_streamer #(
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] ctx_base_addr,
  input  logic [31:0]           ctx_length,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [ADDR_WIDTH-1:0] rd_req_addr,
  input  logic                  rd_rsp_valid,
  input  logic [511:0]          rd_rsp_data,
  output logic [511:0]          fifo_din,
  output logic                  fifo_we,
  input  logic                  fifo_full,
  input  logic                  fifo_almost_full,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state, state_next;
  logic [31:0]           len, len_next;
  logic [31:0]           req_cnt, req_cnt_next;
  logic [31:0]           rsp_cnt, rsp_cnt_next;
  logic [OW-1:0]         outst, outst_next;
  logic [ADDR_WIDTH-1:0] cur_addr, cur_addr_next;
  logic [ADDR_WIDTH-1:0] req_addr_next;
  logic                  req_valid_next;
  logic                  err_next;
  logic                  handshake;
  logic                  rsp_accept;
  logic                  rsp_stray;

  assign handshake  = rd_req_valid & rd_req_ready;
  assign rsp_accept = rd_rsp_valid & (outst != '0);
  assign rsp_stray  = rd_rsp_valid & (outst == '0);

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  always_comb begin
    state_next     = state;
    len_next       = len;
    req_cnt_next   = req_cnt;
    rsp_cnt_next   = rsp_cnt;
    outst_next     = outst;
    cur_addr_next  = cur_addr;
    req_valid_next = rd_req_valid;
    req_addr_next  = rd_req_addr;
    err_next       = err | rsp_stray | (fifo_we & fifo_full);

    if (handshake) begin
      req_cnt_next   = req_cnt + 32'd1;
      cur_addr_next  = cur_addr + 1'b1;
      req_valid_next = 1'b0;
    end
    if (rsp_accept) begin
      rsp_cnt_next = rsp_cnt + 32'd1;
    end

    unique case ({handshake, rsp_accept})
      2'b10:   outst_next = outst + 1'b1;
      2'b01:   outst_next = outst - 1'b1;
      default: outst_next = outst;
    endcase

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          len_next      = ctx_length;
          req_cnt_next  = '0;
          rsp_cnt_next  = '0;
          cur_addr_next = ctx_base_addr;
          state_next    = (ctx_length == 32'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (req_cnt_next == len) begin
          state_next = DRAIN;
        end else if ((!rd_req_valid || handshake) && (outst_next < OUTST_MAX) &&
                     !fifo_almost_full) begin
          // A pending request is never retracted; only a free slot re-arms valid.
          req_valid_next = 1'b1;
          req_addr_next  = cur_addr_next;
        end
      end
      DRAIN: begin
        if (rsp_cnt_next == len) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      len          <= '0;
      req_cnt      <= '0;
      rsp_cnt      <= '0;
      outst        <= '0;
      cur_addr     <= '0;
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      fifo_we      <= 1'b0;
      fifo_din     <= '0;
      err          <= 1'b0;
    end else begin
      state        <= state_next;
      len          <= len_next;
      req_cnt      <= req_cnt_next;
      rsp_cnt      <= rsp_cnt_next;
      outst        <= outst_next;
      cur_addr     <= cur_addr_next;
      rd_req_valid <= req_valid_next;
      rd_req_addr  <= req_addr_next;
      fifo_we      <= rsp_accept;
      if (rsp_accept) begin
        fifo_din <= rd_rsp_data;
      end
      err          <= err_next;
    end
  end

endmodule

// File: tb/tb_afu_read_streamer.sv
// Directed bench for afu_read_streamer: behavioural memory with programmable
// response delay, address and FIFO-data scoreboards, and per-step checks.
module tb_afu_read_streamer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  ctx_base_addr = '0;
  logic [31:0]  ctx_length = '0;
  logic         rd_req_valid;
  logic         rd_req_ready = 1'b1;
  logic [31:0]  rd_req_addr;
  logic         rd_rsp_valid = 1'b0;
  logic [511:0] rd_rsp_data = '0;
  logic [511:0] fifo_din;
  logic         fifo_we;
  logic         fifo_full = 1'b0;
  logic         fifo_almost_full = 1'b0;
  logic         busy;
  logic         done;
  logic         err;

  afu_read_streamer #(.ADDR_WIDTH(32), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ctx_base_addr(ctx_base_addr), .ctx_length(ctx_length),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .fifo_din(fifo_din), .fifo_we(fifo_we),
    .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;

  pend_t        pend_q[$];
  logic [31:0]  exp_addr_q[$];
  logic [511:0] exp_data_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hs_cnt  = 0;
  int wr_cnt  = 0;
  bit hold      = 1'b0;
  bit stray     = 1'b0;
  bit drop_mode = 1'b0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record the request handshake at the coming edge, drive the
  // memory response for that edge, then check any FIFO write it produced.
  task automatic step();
    pend_t p;
    if (rd_req_valid && rd_req_ready) begin
      hs_cnt++;
      if (exp_addr_q.size() == 0) begin
        check("extra_req", rd_req_valid, 1'b0);
      end else begin
        check("req_addr", rd_req_addr, exp_addr_q.pop_front());
      end
      $display("[TB] cyc %0d req addr=%08h", cyc, rd_req_addr);
      pend_q.push_back('{cyc + 3, rd_req_addr});
    end
    rd_rsp_valid = 1'b0;
    rd_rsp_data  = '0;
    if (stray) begin
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = {16{32'hDEADBEEF}};
    end else if (!hold && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      rd_rsp_valid = 1'b1;
      rd_rsp_data  = {16{p.addr}};
      if (!drop_mode) exp_data_q.push_back({16{p.addr}});
    end
    @(negedge clk);
    cyc++;
    if (fifo_we) begin
      wr_cnt++;
      $display("[TB] cyc %0d fifo_we din[31:0]=%08h", cyc, fifo_din[31:0]);
      if (exp_data_q.size() == 0) begin
        check("extra_fifo_we", fifo_we, 1'b0);
      end else begin
        check("fifo_din", fifo_din, exp_data_q.pop_front());
      end
    end
  endtask

  task automatic start_job(input logic [31:0] base, input logic [31:0] len);
    logic [31:0] a;
    for (int i = 0; i < int'(len); i++) begin
      a = base + 32'(i);
      exp_addr_q.push_back(a);
    end
    ctx_base_addr = base;
    ctx_length    = len;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int budget);
    for (int i = 0; i < budget && !done; i++) step();
    check(tag, done, 1'b1);
    for (int i = 0; i < 3; i++) step();
  endtask

  int hs0;
  int wr0;

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", rd_req_valid, 1'b0);
    check("rst_addr", rd_req_addr, 32'h0);
    check("rst_we", fifo_we, 1'b0);
    check("rst_din", fifo_din, 512'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    reset = 1'b0;
    step();

    // 1: basic 4-line job
    hs0 = hs_cnt; wr0 = wr_cnt;
    start_job(32'h100, 32'd4);
    check("t1_busy", busy, 1'b1);
    run_to_done("t1_done", 100);
    check("t1_reqs", 32'(hs_cnt - hs0), 32'd4);
    check("t1_writes", 32'(wr_cnt - wr0), 32'd4);
    check("t1_err", err, 1'b0);
    check("t1_addr_q", 32'(exp_addr_q.size()), 32'd0);

    // 2: zero-length job completes the cycle after start
    hs0 = hs_cnt;
    start_job(32'h180, 32'd0);
    check("t2_done", done, 1'b1);
    check("t2_busy", busy, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check("t2_reqs", 32'(hs_cnt - hs0), 32'd0);
    check("t2_valid", rd_req_valid, 1'b0);

    // 3: responses withheld -> in-flight cap of 4
    hs0 = hs_cnt; wr0 = wr_cnt;
    hold = 1'b1;
    start_job(32'h200, 32'd20);
    for (int i = 0; i < 20; i++) step();
    check("t3_capped_reqs", 32'(hs_cnt - hs0), 32'd4);
    check("t3_valid_low", rd_req_valid, 1'b0);
    check("t3_busy", busy, 1'b1);
    hold = 1'b0;
    for (int i = 0; i < 10 && (hs_cnt - hs0) < 5; i++) step();
    check("t3_resume", 32'(hs_cnt - hs0), 32'd5);
    run_to_done("t3_done", 400);
    check("t3_writes", 32'(wr_cnt - wr0), 32'd20);

    // 4: ready held low while almost_full rises; no retraction
    hs0 = hs_cnt;
    rd_req_ready = 1'b0;
    start_job(32'h300, 32'd2);
    for (int i = 0; i < 10 && !rd_req_valid; i++) step();
    check("t4_valid_up", rd_req_valid, 1'b1);
    check("t4_addr", rd_req_addr, 32'h300);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) fifo_almost_full = 1'b1;
      step();
      check("t4_hold_valid", rd_req_valid, 1'b1);
      check("t4_hold_addr", rd_req_addr, 32'h300);
    end
    rd_req_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) step();
    check("t4_one_hs", 32'(hs_cnt - hs0), 32'd1);
    check("t4_af_block", rd_req_valid, 1'b0);
    fifo_almost_full = 1'b0;
    run_to_done("t4_done", 100);
    check("t4_reqs", 32'(hs_cnt - hs0), 32'd2);

    // 5: address wrap
    hs0 = hs_cnt;
    start_job(32'hFFFF_FFFE, 32'd3);
    run_to_done("t5_done", 100);
    check("t5_reqs", 32'(hs_cnt - hs0), 32'd3);
    check("t5_err", err, 1'b0);

    // 6a: stray response with nothing outstanding
    wr0 = wr_cnt;
    stray = 1'b1;
    step();
    stray = 1'b0;
    check("t6_stray_we", fifo_we, 1'b0);
    check("t6_err", err, 1'b1);
    step();
    check("t6_stray_writes", 32'(wr_cnt - wr0), 32'd0);

    // 6b: asynchronous reset mid-job, then late responses
    start_job(32'h400, 32'd8);
    for (int i = 0; i < 5; i++) step();
    check("t6_midjob_busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("t6_arst_valid", rd_req_valid, 1'b0);
    check("t6_arst_addr", rd_req_addr, 32'h0);
    check("t6_arst_we", fifo_we, 1'b0);
    check("t6_arst_din", fifo_din, 512'h0);
    check("t6_arst_busy", busy, 1'b0);
    check("t6_arst_done", done, 1'b0);
    check("t6_arst_err", err, 1'b0);
    rd_rsp_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    drop_mode = 1'b1;
    wr0 = wr_cnt;
    hs0 = hs_cnt;
    check("t6_pending_late", 32'(pend_q.size() > 0), 32'd1);
    for (int i = 0; i < 8; i++) step();
    check("t6_late_err", err, 1'b1);
    check("t6_late_writes", 32'(wr_cnt - wr0), 32'd0);
    check("t6_idle_reqs", 32'(hs_cnt - hs0), 32'd0);
    check("t6_idle_busy", busy, 1'b0);
    check("t6_idle_done", done, 1'b0);
    check("t6_idle_valid", rd_req_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
